mem_port_arbiter: RTL and testbench

- Shares the single unified memory port between the instruction-fetch requester and the load/store data requester of the multicycle RISC-V core.
- Sits between the control unit / datapath (IR load path and data access path) and the memory.
- Registers the winning request, drives the memory, and waits for mem_ready.
- Returns read data with a one-cycle ack pulse to the winning requester.

---
 rtl/mem_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and load/store data.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating priority on ties; the default gives data priority over fetch.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY_I = 2'd1;
    localparam logic [1:0] ST_BUSY_D = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              i_ack_q, i_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_elig, d_elig, d_win;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // 1 = data was granted last, 0 = fetch was granted last
    logic last_grant_q, last_grant_d;
`endif

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        // A requester still holding req in its ack cycle must not be granted again
        d_elig      = d_req && !d_ack_q;
        i_elig      = i_req && !i_ack_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
        d_win        = d_elig && (!i_elig || !last_grant_q);
`else
        d_win        = d_elig;
`endif
        case (state_q)
            ST_IDLE: begin
                if (d_win) begin
                    state_d     = ST_BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_grant_d = 1'b1;
`endif
                end else if (i_elig) begin
                    state_d    = ST_BUSY_I;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = i_addr;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_grant_d = 1'b0;
`endif
                end
            end
            ST_BUSY_I: begin
                if (mem_ready) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    i_ack_d   = 1'b1;
                    i_rdata_d = mem_rdata;
                end
            end
            ST_BUSY_D: begin
                if (mem_ready) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    d_ack_d   = 1'b1;
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios followed by randomized concurrent requesters.
// Honors MEM_ARB_ROUND_ROBIN_EN the same way the design does.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we, mem_ready;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic        i_ack, d_ack, mem_req, mem_we;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit resp_en = 0;

    typedef struct {
        int          cyc;
        bit          is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } grant_t;

    typedef struct {
        int          cyc;
        bit          is_d;
        logic [31:0] rdata;
    } ack_t;

    grant_t grant_q[$];
    ack_t   ack_q[$];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit is_d, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        if (is_d) begin
            d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
        end else begin
            i_addr = addr; i_req = 1'b1;
        end
    endtask

    // Reference model: one access at a time; a completion is acknowledged in the following
    // cycle, during which that requester cannot win; ties resolved by the priority rule.
    bit          m_busy, m_cur_d, m_we, m_ack_i, m_ack_d, m_last_d;
    logic [31:0] m_i_rdata, m_d_rdata;

    always @(negedge clk) begin
        bit n_ack_i, n_ack_d, d_el, i_el, d_win;
        if (reset) begin
            m_busy = 0; m_ack_i = 0; m_ack_d = 0; m_last_d = 0;
            m_i_rdata = '0; m_d_rdata = '0;
            grant_q.delete();
            ack_q.delete();
        end else begin
            n_ack_i = 0;
            n_ack_d = 0;
            if (m_busy) begin
                if (mem_ready) begin
                    if (m_cur_d) begin
                        if (!m_we) m_d_rdata = mem_rdata;
                        ack_q.push_back('{cyc: cyc + 1, is_d: 1'b1, rdata: m_d_rdata});
                        n_ack_d = 1;
                    end else begin
                        m_i_rdata = mem_rdata;
                        ack_q.push_back('{cyc: cyc + 1, is_d: 1'b0, rdata: m_i_rdata});
                        n_ack_i = 1;
                    end
                    m_busy = 0;
                end
            end else begin
                d_el = d_req && !m_ack_d;
                i_el = i_req && !m_ack_i;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                d_win = d_el && (!i_el || !m_last_d);
`else
                d_win = d_el;
`endif
                if (d_win) begin
                    grant_q.push_back('{cyc: cyc + 1, is_d: 1'b1, we: d_we, addr: d_addr, wdata: d_wdata});
                    m_busy = 1; m_cur_d = 1; m_we = d_we; m_last_d = 1;
                end else if (i_el) begin
                    grant_q.push_back('{cyc: cyc + 1, is_d: 1'b0, we: 1'b0, addr: i_addr, wdata: '0});
                    m_busy = 1; m_cur_d = 0; m_we = 0; m_last_d = 0;
                end
            end
            m_ack_i = n_ack_i;
            m_ack_d = n_ack_d;
        end
    end

    // Monitor: compares grants, held memory-port values and acks against the scoreboard queues
    bit     prev_mem_req = 0;
    grant_t held;

    always @(negedge clk) begin
        grant_t g;
        ack_t   a;
        if (reset) begin
            prev_mem_req = 0;
        end else begin
            checkOutput("ack exclusive", 32'(i_ack & d_ack), 32'd0);
            if (grant_q.size() > 0 && grant_q[0].cyc == cyc) begin
                g = grant_q.pop_front();
                checkOutput("grant new mem_req", 32'(mem_req && !prev_mem_req), 32'd1);
                checkOutput("grant mem_addr", mem_addr, g.addr);
                checkOutput("grant mem_we", 32'(mem_we), 32'(g.we));
                if (g.is_d) checkOutput("grant mem_wdata", mem_wdata, g.wdata);
                held = g;
            end else if (mem_req && !prev_mem_req) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected grant: mem_req rose at cycle %0d, expected none", cyc);
            end else if (mem_req && prev_mem_req) begin
                checkOutput("hold mem_addr", mem_addr, held.addr);
                checkOutput("hold mem_we", 32'(mem_we), 32'(held.we));
                if (held.is_d) checkOutput("hold mem_wdata", mem_wdata, held.wdata);
            end
            if (ack_q.size() > 0 && ack_q[0].cyc == cyc) begin
                a = ack_q.pop_front();
                checkOutput("ack mem_req low", 32'(mem_req), 32'd0);
                checkOutput(a.is_d ? "d_ack pulse" : "i_ack pulse", 32'(a.is_d ? d_ack : i_ack), 32'd1);
                if (a.is_d) checkOutput("d_rdata", d_rdata, a.rdata);
                else        checkOutput("i_rdata", i_rdata, a.rdata);
            end else begin
                checkOutput("no i_ack", 32'(i_ack), 32'd0);
                checkOutput("no d_ack", 32'(d_ack), 32'd0);
            end
            prev_mem_req = mem_req;
        end
    end

    // Random memory responder, active only in the randomized phase
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (resp_en) begin
                mem_ready = ($urandom_range(0, 9) < 4);
                mem_rdata = $urandom;
            end
        end
    end

    task automatic randomRequester(input bit is_d, input int count);
        int t;
        for (int n = 0; n < count; n++) begin
            repeat ($urandom_range(0, 3)) cycle();
            cycle();
            applyStimulus(is_d, 1'($urandom_range(0, 1)), $urandom & 32'h0000_0FFC, $urandom);
            t = 0;
            do begin
                sample();
                t++;
            end while (!(is_d ? d_ack : i_ack) && t < 100);
            if (t >= 100) begin
                checks++;
                errors++;
                $display("[TB] FAIL %s timeout: got no ack, expected ack within 100 cycles",
                         is_d ? "data" : "fetch");
            end
            if ($urandom_range(0, 1) == 1) cycle();
            if (is_d) d_req = 1'b0;
            else      i_req = 1'b0;
        end
    endtask

    task automatic tieTest(input bit data_first, input logic [31:0] fa, input logic [31:0] da,
                           input logic [31:0] r1, input logic [31:0] r2);
        cycle();
        applyStimulus(1'b0, 1'b0, fa, '0);
        applyStimulus(1'b1, 1'b0, da, '0);
        cycle();
        mem_ready = 1'b1; mem_rdata = r1;
        sample();
        checkOutput("tie first addr", mem_addr, data_first ? da : fa);
        cycle();
        mem_ready = 1'b0;
        sample();
        checkOutput("tie first ack", 32'(data_first ? d_ack : i_ack), 32'd1);
        checkOutput("tie first rdata", data_first ? d_rdata : i_rdata, r1);
        checkOutput("tie idle gap", 32'(mem_req), 32'd0);
        if (data_first) d_req = 1'b0;
        else            i_req = 1'b0;
        cycle();
        mem_ready = 1'b1; mem_rdata = r2;
        sample();
        checkOutput("tie second addr", mem_addr, data_first ? fa : da);
        cycle();
        mem_ready = 1'b0;
        sample();
        checkOutput("tie second ack", 32'(data_first ? i_ack : d_ack), 32'd1);
        checkOutput("tie second rdata", data_first ? i_rdata : d_rdata, r2);
        i_req = 1'b0;
        d_req = 1'b0;
        cycle();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no completion, expected finish within 1000000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        i_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        repeat (2) cycle();
        sample();
        checkOutput("reset mem_req", 32'(mem_req), 32'd0);
        checkOutput("reset mem_we", 32'(mem_we), 32'd0);
        checkOutput("reset acks", 32'({i_ack, d_ack}), 32'd0);
        checkOutput("reset mem_addr", mem_addr, 32'd0);
        checkOutput("reset mem_wdata", mem_wdata, 32'd0);
        checkOutput("reset i_rdata", i_rdata, 32'd0);
        checkOutput("reset d_rdata", d_rdata, 32'd0);
        cycle();
        reset = 1'b0;

        // First tie after reset: data wins in both priority modes
        tieTest(1'b1, 32'h0000_0040, 32'h0000_0200, 32'h0000_1234, 32'hCAFE_0001);

        // Lone fetch, memory ready from cycle 2
        cycle();
        applyStimulus(1'b0, 1'b0, 32'h0000_0010, '0);
        cycle();
        sample();
        checkOutput("fetch mem_req", 32'(mem_req), 32'd1);
        checkOutput("fetch mem_addr", mem_addr, 32'h0000_0010);
        checkOutput("fetch mem_we", 32'(mem_we), 32'd0);
        cycle();
        mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
        sample();
        checkOutput("fetch busy", 32'(mem_req), 32'd1);
        cycle();
        mem_ready = 1'b0;
        sample();
        checkOutput("fetch i_ack", 32'(i_ack), 32'd1);
        checkOutput("fetch i_rdata", i_rdata, 32'h0050_0093);
        i_req = 1'b0;
        cycle();
        sample();
        checkOutput("fetch ack single", 32'(i_ack), 32'd0);

        // Store with three wait cycles
        cycle();
        applyStimulus(1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
        for (int k = 0; k < 4; k++) begin
            cycle();
            if (k == 3) mem_ready = 1'b1;
            sample();
            checkOutput("store mem_req", 32'(mem_req), 32'd1);
            checkOutput("store mem_we", 32'(mem_we), 32'd1);
            checkOutput("store mem_addr", mem_addr, 32'h0000_0100);
            checkOutput("store mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        end
        cycle();
        mem_ready = 1'b0;
        sample();
        checkOutput("store d_ack", 32'(d_ack), 32'd1);
        checkOutput("store d_rdata kept", d_rdata, 32'h0000_1234);
        d_req = 1'b0;
        cycle();
        sample();
        checkOutput("store ack single", 32'(d_ack), 32'd0);

        // Data was granted last; round-robin now favours fetch on a tie
`ifdef MEM_ARB_ROUND_ROBIN_EN
        tieTest(1'b0, 32'h0000_0044, 32'h0000_0204, 32'h1111_0000, 32'h2222_0000);
`else
        tieTest(1'b1, 32'h0000_0044, 32'h0000_0204, 32'h1111_0000, 32'h2222_0000);
`endif

        // Fetch requester keeps i_req high through its ack cycle
        cycle();
        applyStimulus(1'b0, 1'b0, 32'h0000_0080, '0);
        cycle();
        mem_ready = 1'b1; mem_rdata = 32'h0000_0013;
        cycle();
        mem_ready = 1'b0;
        sample();
        checkOutput("hold i_ack", 32'(i_ack), 32'd1);
        cycle();
        i_req = 1'b0;
        sample();
        checkOutput("hold no regrant", 32'(mem_req), 32'd0);
        checkOutput("hold no second ack", 32'(i_ack), 32'd0);

        // Reset in the middle of a data access
        cycle();
        applyStimulus(1'b1, 1'b0, 32'h0000_0300, '0);
        cycle();
        sample();
        checkOutput("pre-reset busy", 32'(mem_req), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("async reset mem_req", 32'(mem_req), 32'd0);
        d_req = 1'b0;
        repeat (2) begin
            cycle();
            mem_ready = 1'b1;
            sample();
            checkOutput("reset no d_ack", 32'(d_ack), 32'd0);
        end
        cycle();
        mem_ready = 1'b0;
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0000_0020, '0);
        cycle();
        mem_ready = 1'b1; mem_rdata = 32'h00A0_0113;
        cycle();
        mem_ready = 1'b0;
        sample();
        checkOutput("post-reset i_ack", 32'(i_ack), 32'd1);
        checkOutput("post-reset i_rdata", i_rdata, 32'h00A0_0113);
        i_req = 1'b0;

        // mem_ready pulsing while idle
        cycle();
        mem_ready = 1'b1;
        repeat (2) begin
            cycle();
            sample();
            checkOutput("idle ready no grant", 32'(mem_req), 32'd0);
            checkOutput("idle ready no ack", 32'({i_ack, d_ack}), 32'd0);
        end
        cycle();
        mem_ready = 1'b0;

        // Randomized concurrent requesters against the random responder
        resp_en = 1;
        fork
            randomRequester(1'b0, 60);
            randomRequester(1'b1, 60);
        join
        resp_en = 0;
        mem_ready = 1'b0;
        repeat (4) cycle();
        sample();
        checkOutput("scoreboard drained", 32'(grant_q.size() + ack_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
